// File: rtl/fpu_share_arbiter.sv
// rtl/fpu_share_arbiter.sv - round-robin sharing of one fixed-latency float unit with tag tracking and drain/halt
// Optional busy-cycle counter: define FPU_ARB_BUSY_CNT_EN.
module fpu_share_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 3,
    parameter int W   = 24
) (
    input  logic           clk,
    input  logic           rst,
`ifdef FPU_ARB_BUSY_CNT_EN
    output logic [15:0]    busy_cnt,
`endif
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_data,
    output logic [W-1:0]   fpu_a,
    output logic [W-1:0]   fpu_b,
    input  logic [W-1:0]   fpu_out,
    input  logic           drain_req,
    output logic           halted
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt_idx;
    logic            xfer;
    logic            pending;
    logic            halt_entry;
    logic [LAT-1:0]  tag_v;
    logic [IW-1:0]   tag_idx [LAT];

    // Descending scan so the nearest requester above the pointer is written last and wins.
    always_comb begin
        int j;
        j         = 0;
        gnt_idx   = ptr;
        xfer      = 1'b0;
        req_ready = '0;
        if (state == RUN && !drain_req && !rst) begin
            for (int k = N; k >= 1; k--) begin
                j = (int'(ptr) + k) % N;
                if (req_valid[j]) begin
                    gnt_idx = IW'(j);
                    xfer    = 1'b1;
                end
            end
            if (xfer) req_ready[gnt_idx] = 1'b1;
        end
    end

    // Anything that will still be in flight after this edge's shift.
    always_comb begin
        pending = 1'b0;
        for (int s = 0; s < LAT - 1; s++) pending = pending | tag_v[s];
    end

    assign halt_entry = (state == DRAIN) && drain_req && !pending;

    always_comb begin
        rsp_valid = '0;
        if (tag_v[LAT-1]) rsp_valid[tag_idx[LAT-1]] = 1'b1;
    end

    assign rsp_data = fpu_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            ptr    <= IW'(N - 1);
            fpu_a  <= '0;
            fpu_b  <= '0;
            halted <= 1'b0;
            tag_v  <= '0;
            for (int s = 0; s < LAT; s++) tag_idx[s] <= '0;
        end else begin
            for (int s = LAT - 1; s > 0; s--) begin
                tag_v[s]   <= tag_v[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
            tag_v[0]   <= xfer;
            tag_idx[0] <= gnt_idx;
            if (xfer) begin
                fpu_a <= req_a[int'(gnt_idx)*W +: W];
                fpu_b <= req_b[int'(gnt_idx)*W +: W];
                ptr   <= gnt_idx;
            end
            case (state)
                RUN: begin
                    if (drain_req) state <= DRAIN;
                    halted <= 1'b0;
                end
                DRAIN: begin
                    if (!drain_req) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end else if (!pending) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (!drain_req) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef FPU_ARB_BUSY_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || halt_entry) begin
            busy_cnt <= '0;
        end else if (xfer && busy_cnt != 16'hFFFF) begin
            busy_cnt <= busy_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb/tb_fpu_share_arbiter.sv - self-checking bench for fpu_share_arbiter (table-driven plus reset/drain sequences)
module tb_fpu_share_arbiter;

    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int W   = 24;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic [W-1:0]   fpu_a;
    logic [W-1:0]   fpu_b;
    logic [W-1:0]   fpu_out;
    logic           drain_req;
    logic           halted;
`ifdef FPU_ARB_BUSY_CNT_EN
    logic [15:0]    busy_cnt;
`endif

    int checks;
    int errors;

    fpu_share_arbiter #(.N(N), .LAT(LAT), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef FPU_ARB_BUSY_CNT_EN
        .busy_cnt  (busy_cnt),
`endif
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .fpu_a     (fpu_a),
        .fpu_b     (fpu_b),
        .fpu_out   (fpu_out),
        .drain_req (drain_req),
        .halted    (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Float unit model: A+B on the raw words, result visible LAT cycles after the handshake cycle.
    logic [W-1:0] m1, m2;
    always_ff @(posedge clk) begin
        m1 <= fpu_a + fpu_b;
        m2 <= m1;
    end
    assign fpu_out = m2;

    // Fixed per-requester operands; sums are 7FC000, 100011, 200022, 300033.
    assign req_a = {24'h300003, 24'h200002, 24'h100001, 24'h414000};
    assign req_b = {24'h000030, 24'h000020, 24'h000010, 24'h3E8000};

    typedef struct {
        logic        drain;
        logic [3:0]  rv;
        logic [3:0]  rdy;
        logic [3:0]  rsp;
        logic [23:0] data;
        logic        hlt;
    } vec_t;

    vec_t tbl [35];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // contention: grants 0,1,2,3,0,1,2,3
        tbl[0]  = '{1'b0, 4'hF, 4'h1, 4'h0, 24'h0,      1'b0};
        tbl[1]  = '{1'b0, 4'hF, 4'h2, 4'h0, 24'h0,      1'b0};
        tbl[2]  = '{1'b0, 4'hF, 4'h4, 4'h0, 24'h0,      1'b0};
        tbl[3]  = '{1'b0, 4'hF, 4'h8, 4'h1, 24'h7FC000, 1'b0};
        tbl[4]  = '{1'b0, 4'hF, 4'h1, 4'h2, 24'h100011, 1'b0};
        tbl[5]  = '{1'b0, 4'hF, 4'h2, 4'h4, 24'h200022, 1'b0};
        tbl[6]  = '{1'b0, 4'hF, 4'h4, 4'h8, 24'h300033, 1'b0};
        tbl[7]  = '{1'b0, 4'hF, 4'h8, 4'h1, 24'h7FC000, 1'b0};
        tbl[8]  = '{1'b0, 4'h0, 4'h0, 4'h2, 24'h100011, 1'b0};
        tbl[9]  = '{1'b0, 4'h0, 4'h0, 4'h4, 24'h200022, 1'b0};
        tbl[10] = '{1'b0, 4'h0, 4'h0, 4'h8, 24'h300033, 1'b0};
        // single op on requester 0
        tbl[11] = '{1'b0, 4'h1, 4'h1, 4'h0, 24'h0,      1'b0};
        tbl[12] = '{1'b0, 4'h0, 4'h0, 4'h0, 24'h0,      1'b0};
        tbl[13] = '{1'b0, 4'h0, 4'h0, 4'h0, 24'h0,      1'b0};
        // sparse fairness from pointer 0: 2,0,2,0, then a bubble
        tbl[14] = '{1'b0, 4'h5, 4'h4, 4'h1, 24'h7FC000, 1'b0};
        tbl[15] = '{1'b0, 4'h5, 4'h1, 4'h0, 24'h0,      1'b0};
        tbl[16] = '{1'b0, 4'h5, 4'h4, 4'h0, 24'h0,      1'b0};
        tbl[17] = '{1'b0, 4'h5, 4'h1, 4'h4, 24'h200022, 1'b0};
        tbl[18] = '{1'b0, 4'h0, 4'h0, 4'h1, 24'h7FC000, 1'b0};
        tbl[19] = '{1'b0, 4'h0, 4'h0, 4'h4, 24'h200022, 1'b0};
        tbl[20] = '{1'b0, 4'h0, 4'h0, 4'h1, 24'h7FC000, 1'b0};
        tbl[21] = '{1'b0, 4'h0, 4'h0, 4'h0, 24'h0,      1'b0};
        tbl[22] = '{1'b0, 4'h0, 4'h0, 4'h0, 24'h0,      1'b0};
        // drain: three ops, then drain_req; halt after the last response; resume at requester 0
        tbl[23] = '{1'b0, 4'hF, 4'h2, 4'h0, 24'h0,      1'b0};
        tbl[24] = '{1'b0, 4'hF, 4'h4, 4'h0, 24'h0,      1'b0};
        tbl[25] = '{1'b0, 4'hF, 4'h8, 4'h0, 24'h0,      1'b0};
        tbl[26] = '{1'b1, 4'hF, 4'h0, 4'h2, 24'h100011, 1'b0};
        tbl[27] = '{1'b1, 4'hF, 4'h0, 4'h4, 24'h200022, 1'b0};
        tbl[28] = '{1'b1, 4'hF, 4'h0, 4'h8, 24'h300033, 1'b0};
        tbl[29] = '{1'b1, 4'hF, 4'h0, 4'h0, 24'h0,      1'b1};
        tbl[30] = '{1'b0, 4'hF, 4'h0, 4'h0, 24'h0,      1'b1};
        tbl[31] = '{1'b0, 4'hF, 4'h1, 4'h0, 24'h0,      1'b0};
        tbl[32] = '{1'b0, 4'h0, 4'h0, 4'h0, 24'h0,      1'b0};
        tbl[33] = '{1'b0, 4'h0, 4'h0, 4'h0, 24'h0,      1'b0};
        tbl[34] = '{1'b0, 4'h0, 4'h0, 4'h1, 24'h7FC000, 1'b0};

        rst       = 1'b1;
        req_valid = '0;
        drain_req = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_fpu_a", 32'(fpu_a), 32'h0);
        check("reset_fpu_b", 32'(fpu_b), 32'h0);
        check("reset_halted", 32'(halted), 32'h0);

        for (int i = 0; i < 35; i++) begin
            next_cycle();
            drain_req = tbl[i].drain;
            req_valid = tbl[i].rv;
            @(negedge clk);
            check($sformatf("row%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            check($sformatf("row%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].rsp));
            check($sformatf("row%0d_halted", i), 32'(halted), 32'(tbl[i].hlt));
            if (tbl[i].rsp != 4'h0)
                check($sformatf("row%0d_rsp_data", i), 32'(rsp_data), 32'(tbl[i].data));
        end

        // reset mid-flight: two ops (grants 1 then 0 from pointer 0), then a one-cycle reset
        next_cycle();
        req_valid = 4'h3;
        @(negedge clk);
        check("mid_grant1", 32'(req_ready), 32'h2);
        next_cycle();
        @(negedge clk);
        check("mid_grant0", 32'(req_ready), 32'h1);
        next_cycle();
        req_valid = 4'h0;
        rst       = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("post_rst_req_ready", 32'(req_ready), 32'h0);
        check("post_rst_fpu_a", 32'(fpu_a), 32'h0);
        check("post_rst_fpu_b", 32'(fpu_b), 32'h0);
        check("post_rst_halted", 32'(halted), 32'h0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("post_rst_quiet%0d", i), 32'(rsp_valid), 32'h0);
        end
        next_cycle();
        req_valid = 4'hF;
        @(negedge clk);
        check("post_rst_first_grant", 32'(req_ready), 32'h1);

`ifdef FPU_ARB_BUSY_CNT_EN
        // that grant is transfer 1; four more make 5
        for (int i = 0; i < 4; i++) next_cycle();
        next_cycle();
        req_valid = 4'h0;
        @(negedge clk);
        check("busy_cnt_five", 32'(busy_cnt), 32'd5);
        drain_req = 1'b1;
        begin
            int budget;
            budget = 0;
            while (!halted && budget < 20) begin
                next_cycle();
                @(negedge clk);
                budget++;
            end
            check("busy_halt_reached", 32'(halted), 32'h1);
            check("busy_cnt_cleared", 32'(busy_cnt), 32'd0);
        end
        next_cycle();
        drain_req = 1'b0;
`endif

        next_cycle();
        req_valid = 4'h0;
        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
